// File: rtl/count_macro_sequencer.sv
// rtl/count_macro_sequencer.sv - resets, clocks and checks the 4-bit count macro
// Drives the macro's clock and reset pins and scores each synchronised count sample.
module count_macro_sequencer #(
  parameter int DIV_W       = 8,
  parameter int NPULSE_W    = 8,
  parameter int RST_CYCLES  = 4,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIV_W-1:0]    half_period,
  input  logic [NPULSE_W-1:0] n_pulses,
  input  logic [3:0]          count_in,
  output logic                count_clk,
  output logic                count_rst_n,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count,
  output logic [NPULSE_W-1:0] first_err_idx,
  output logic [3:0]          last_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRST, S_WAIT, S_SAMPLE, S_PHI, S_PLO, S_FIN
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    hp_q;
  logic [NPULSE_W-1:0] npulse_q;
  logic [NPULSE_W-1:0] idx_q;
  logic                count_clk_q;
  logic                count_rst_n_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [7:0]          err_count_q;
  logic [NPULSE_W-1:0] first_err_idx_q;
  logic [3:0]          last_count_q;

  logic [3:0]          sync_q [SYNC_STAGES];
  logic [3:0]          count_sync;
  logic                mismatch;
  logic [7:0]          err_count_d;

  // count_in is asynchronous to clk; only the last synchroniser stage is ever compared
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
    end else begin
      sync_q[0] <= count_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign count_sync  = sync_q[SYNC_STAGES-1];
  assign mismatch    = (count_sync != idx_q[3:0]);
  assign err_count_d = !mismatch ? err_count_q :
                       (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      hp_q            <= '0;
      npulse_q        <= '0;
      idx_q           <= '0;
      count_clk_q     <= 1'b0;
      count_rst_n_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= 8'd0;
      first_err_idx_q <= '0;
      last_count_q    <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          count_clk_q <= 1'b0;
          if (start) begin
            hp_q            <= (half_period == '0) ? DIV_W'(1) : half_period;
            npulse_q        <= n_pulses;
            idx_q           <= '0;
            err_count_q     <= 8'd0;
            first_err_idx_q <= '0;
            pass_q          <= 1'b0;
            busy_q          <= 1'b1;
            count_rst_n_q   <= 1'b0;
            cnt_q           <= DIV_W'(RST_CYCLES - 1);
            state_q         <= S_MRST;
          end
        end
        S_MRST: begin
          if (cnt_q == '0) begin
            count_rst_n_q <= 1'b1;
            cnt_q         <= DIV_W'(SETTLE - 1);
            state_q       <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_SAMPLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_SAMPLE: begin
          last_count_q <= count_sync;
          err_count_q  <= err_count_d;
          if (mismatch && (err_count_q == 8'd0)) first_err_idx_q <= idx_q;
          if (idx_q == npulse_q) begin
            // pass is settled here so it is already valid while done is high
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_count_d == 8'd0);
            state_q <= S_FIN;
          end else begin
            idx_q       <= idx_q + 1'b1;
            count_clk_q <= 1'b1;
            cnt_q       <= hp_q - 1'b1;
            state_q     <= S_PHI;
          end
        end
        S_PHI: begin
          if (cnt_q == '0) begin
            count_clk_q <= 1'b0;
            cnt_q       <= hp_q - 1'b1;
            state_q     <= S_PLO;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PLO: begin
          if (cnt_q == '0) begin
            cnt_q   <= DIV_W'(SETTLE - 1);
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign count_clk     = count_clk_q;
  assign count_rst_n   = count_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign last_count    = last_count_q;

endmodule
